// File: rtl/smac_seq_ctrl_if.sv
// Operand-fetch and result valid/ready handshakes between the SMAC lane
// sequencer and its producer/consumer.
interface smac_seq_ctrl_if;
    logic in_valid;
    logic in_ready;
    logic out_valid;
    logic out_ready;

    // master is the operand buffer / result consumer side
    modport master (
        output in_valid,
        output out_ready,
        input  in_ready,
        input  out_valid
    );

    modport slave (
        input  in_valid,
        input  out_ready,
        output in_ready,
        output out_valid
    );
endinterface

// File: rtl/smac_seq_ctrl.sv
// Sequencer for one SMAC lane: fetches operand pairs, drives P bit-serial
// shift steps per pair, accumulates N products and hands the result out.
module smac_seq_ctrl #(
    parameter int Pw  = 8,
    parameter int OPW = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            abort,
    input  logic [1:0]      par_sel_Pw,
    input  logic [OPW-1:0]  n_ops,
    smac_seq_ctrl_if.slave  bus,
    output logic            ld_op,
    output logic            w_shift,
    output logic            ac2_cnt,
    output logic            ac1_en,
    output logic            acc_clr,
    output logic            cnt_clear,
    output logic            busy,
    output logic            done
);
    localparam int CW = $clog2(Pw) + 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        ACC,
        OUT
    } state_t;

    state_t          state;
    logic [CW-1:0]   bit_cnt;
    logic [CW-1:0]   p_steps;
    logic [CW-1:0]   p_sel;
    logic [OPW-1:0]  op_cnt;
    logic [OPW-1:0]  n_lat;

    always_comb begin
        p_sel = CW'(Pw);
        case (par_sel_Pw)
            2'b00:   p_sel = CW'(Pw / 2);
            2'b01:   p_sel = CW'(Pw - 2);
            default: p_sel = CW'(Pw);
        endcase
    end

    // Pulse outputs default low every cycle; abort beats every other transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            op_cnt    <= '0;
            p_steps   <= CW'(Pw);
            n_lat     <= OPW'(1);
            acc_clr   <= 1'b0;
            cnt_clear <= 1'b0;
            done      <= 1'b0;
        end else begin
            acc_clr   <= 1'b0;
            cnt_clear <= 1'b0;
            done      <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                cnt_clear <= 1'b1;
                op_cnt    <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            p_steps   <= p_sel;
                            n_lat     <= (n_ops == '0) ? OPW'(1) : n_ops;
                            op_cnt    <= '0;
                            acc_clr   <= 1'b1;
                            cnt_clear <= 1'b1;
                            state     <= LOAD;
                        end
                    end
                    LOAD: begin
                        if (bus.in_valid) begin
                            bit_cnt <= '0;
                            state   <= SHIFT;
                        end
                    end
                    SHIFT: begin
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == p_steps - CW'(1)) begin
                            state <= ACC;
                        end
                    end
                    ACC: begin
                        // n_lat is never zero, so the last index cannot wrap
                        if (op_cnt == n_lat - OPW'(1)) begin
                            state <= OUT;
                        end else begin
                            op_cnt <= op_cnt + OPW'(1);
                            state  <= LOAD;
                        end
                    end
                    OUT: begin
                        if (bus.out_ready) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.in_ready  = (state == LOAD);
    assign ld_op         = (state == LOAD) && bus.in_valid && !abort;
    assign w_shift       = (state == SHIFT);
    assign ac2_cnt       = (state == SHIFT);
    assign ac1_en        = (state == ACC);
    assign bus.out_valid = (state == OUT);
    assign busy          = (state != IDLE);
endmodule

// File: tb/tb_smac_seq_ctrl.sv
// Directed bench for smac_seq_ctrl: cycle-accurate timing, stalls, abort,
// reset and ignored inputs while busy, all against hand-computed values.
module tb_smac_seq_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  par_sel_Pw = 2'b10;
    logic [15:0] n_ops = 16'd1;
    logic        ld_op, w_shift, ac2_cnt, ac1_en, acc_clr, cnt_clear, busy, done;

    smac_seq_ctrl_if bus ();

    smac_seq_ctrl #(.Pw(8), .OPW(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .par_sel_Pw (par_sel_Pw),
        .n_ops      (n_ops),
        .bus        (bus),
        .ld_op      (ld_op),
        .w_shift    (w_shift),
        .ac2_cnt    (ac2_cnt),
        .ac1_en     (ac1_en),
        .acc_clr    (acc_clr),
        .cnt_clear  (cnt_clear),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int check_cnt = 0;
    int error_cnt = 0;

    int shift_cnt, burst_cnt, max_burst, ac1_cnt, ld_cnt, load_cycles;
    int first_shift, last_shift, last_ac1, first_out_valid, out_valid_cycles;
    int done_cycle, acc_clr_cycle, cnt_clr_cycle, ac2_diff;
    int iv_stall_pair = -1;
    int iv_stall_len = 0;
    int or_stall_len = 0;
    int mid_start_cycle = -1;

    task automatic checkOutput(input string tag, input int actual, input int expected);
        check_cnt++;
        if (actual !== expected) begin
            error_cnt++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    function automatic int allOutputs();
        return int'({ld_op, w_shift, ac2_cnt, ac1_en, acc_clr, cnt_clear, busy, done,
                     bus.in_ready, bus.out_valid});
    endfunction

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    // Start edge is the next rising edge; on return we sit in cycle 1.
    task automatic applyStimulus(input logic [1:0] sel, input logic [15:0] nops);
        par_sel_Pw = sel;
        n_ops      = nops;
        start      = 1'b1;
        stepCycle();
        start      = 1'b0;
    endtask

    // Walks the job cycle by cycle from cycle 1, recording event cycles until done.
    task automatic observe(input int limit);
        int run = 0;
        int iv_stalled = 0;
        shift_cnt = 0; burst_cnt = 0; max_burst = 0; ac1_cnt = 0; ld_cnt = 0;
        load_cycles = 0; first_shift = -1; last_shift = -1; last_ac1 = -1;
        first_out_valid = -1; out_valid_cycles = 0; done_cycle = -1;
        acc_clr_cycle = -1; cnt_clr_cycle = -1; ac2_diff = 0;
        for (int c = 1; c <= limit; c++) begin
            bus.in_valid  = !(ld_cnt == iv_stall_pair && iv_stalled < iv_stall_len);
            bus.out_ready = (out_valid_cycles >= or_stall_len);
            if (c == mid_start_cycle) begin
                start = 1'b1; par_sel_Pw = 2'b00; n_ops = 16'd5;
            end else begin
                start = 1'b0;
            end
            #1;
            if (bus.in_ready) begin
                load_cycles++;
                if (!bus.in_valid) iv_stalled++;
            end
            if (ld_op) ld_cnt++;
            if (ac2_cnt !== w_shift) ac2_diff++;
            if (w_shift) begin
                shift_cnt++;
                if (run == 0) burst_cnt++;
                run++;
                if (run > max_burst) max_burst = run;
                if (first_shift < 0) first_shift = c;
                last_shift = c;
            end else begin
                run = 0;
            end
            if (ac1_en) begin ac1_cnt++; last_ac1 = c; end
            if (bus.out_valid) begin
                if (first_out_valid < 0) first_out_valid = c;
                out_valid_cycles++;
            end
            if (acc_clr) acc_clr_cycle = c;
            if (cnt_clear) cnt_clr_cycle = c;
            if (done) begin done_cycle = c; break; end
            stepCycle();
        end
        start = 1'b0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_outputs", allOutputs(), 0);
        rst_n = 1'b1;
        stepCycle();
        checkOutput("idle_after_reset", allOutputs(), 0);

        // Full-precision single pair
        applyStimulus(2'b10, 16'd1);
        observe(100);
        checkOutput("t1_acc_clr_cycle", acc_clr_cycle, 1);
        checkOutput("t1_cnt_clr_cycle", cnt_clr_cycle, 1);
        checkOutput("t1_first_shift", first_shift, 2);
        checkOutput("t1_last_shift", last_shift, 9);
        checkOutput("t1_shift_cnt", shift_cnt, 8);
        checkOutput("t1_ac1_cycle", last_ac1, 10);
        checkOutput("t1_out_valid", first_out_valid, 11);
        checkOutput("t1_done", done_cycle, 12);
        checkOutput("t1_ac2_eq_shift", ac2_diff, 0);
        checkOutput("t1_idle_after_done", int'(busy), 0);

        // Half precision, three pairs back-to-back
        applyStimulus(2'b00, 16'd3);
        observe(100);
        checkOutput("t2_shift_cnt", shift_cnt, 12);
        checkOutput("t2_bursts", burst_cnt, 3);
        checkOutput("t2_max_burst", max_burst, 4);
        checkOutput("t2_ac1_cnt", ac1_cnt, 3);
        checkOutput("t2_ld_cnt", ld_cnt, 3);
        checkOutput("t2_out_valid", first_out_valid, 19);
        checkOutput("t2_done", done_cycle, 20);

        // Pw-2 steps with a five-cycle operand stall before the second pair
        iv_stall_pair = 1; iv_stall_len = 5;
        applyStimulus(2'b01, 16'd2);
        observe(100);
        iv_stall_pair = -1; iv_stall_len = 0;
        checkOutput("t3_shift_cnt", shift_cnt, 12);
        checkOutput("t3_max_burst", max_burst, 6);
        checkOutput("t3_bursts", burst_cnt, 2);
        checkOutput("t3_load_cycles", load_cycles, 7);
        checkOutput("t3_ld_cnt", ld_cnt, 2);
        checkOutput("t3_out_valid", first_out_valid, 22);

        // Abort in the third SHIFT cycle of the first pair
        applyStimulus(2'b10, 16'd2);
        stepCycle(); stepCycle(); stepCycle();
        checkOutput("t4_shift_before_abort", int'(w_shift), 1);
        abort = 1'b1;
        stepCycle();
        abort = 1'b0;
        checkOutput("t4_busy_after_abort", int'(busy), 0);
        checkOutput("t4_cnt_clear_pulse", int'(cnt_clear), 1);
        checkOutput("t4_no_done", int'(done), 0);
        stepCycle();
        checkOutput("t4_cnt_clear_ends", int'(cnt_clear), 0);
        checkOutput("t4_still_no_done", int'(done), 0);
        // abort beats a simultaneous start in IDLE
        start = 1'b1; abort = 1'b1;
        stepCycle();
        start = 1'b0; abort = 1'b0;
        checkOutput("t4_abort_over_start_busy", int'(busy), 0);
        checkOutput("t4_abort_over_start_accclr", int'(acc_clr), 0);
        checkOutput("t4_abort_over_start_cntclr", int'(cnt_clear), 1);
        applyStimulus(2'b00, 16'd1);
        observe(100);
        checkOutput("t4_restart_shifts", shift_cnt, 4);
        checkOutput("t4_restart_out_valid", first_out_valid, 7);
        checkOutput("t4_restart_done", done_cycle, 8);

        // n_ops=0 acts as one pair; start and par_sel changes mid-job are ignored
        mid_start_cycle = 3;
        applyStimulus(2'b10, 16'd0);
        observe(100);
        mid_start_cycle = -1;
        checkOutput("t5_shift_cnt", shift_cnt, 8);
        checkOutput("t5_ac1_cnt", ac1_cnt, 1);
        checkOutput("t5_out_valid", first_out_valid, 11);
        checkOutput("t5_done", done_cycle, 12);
        stepCycle();
        checkOutput("t5_no_late_start", int'(busy), 0);

        // Result held while consumer stalls four cycles
        or_stall_len = 4;
        applyStimulus(2'b10, 16'd1);
        observe(100);
        or_stall_len = 0;
        checkOutput("t6_out_valid", first_out_valid, 11);
        checkOutput("t6_out_valid_cycles", out_valid_cycles, 5);
        checkOutput("t6_done", done_cycle, 16);

        // Asynchronous reset during SHIFT
        applyStimulus(2'b10, 16'd2);
        stepCycle(); stepCycle();
        checkOutput("t6_shift_before_reset", int'(w_shift), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_reset_outputs", allOutputs(), 0);
        stepCycle();
        checkOutput("t6_reset_held", allOutputs(), 0);
        #2;
        rst_n = 1'b1;
        stepCycle();
        applyStimulus(2'b01, 16'd1);
        observe(100);
        checkOutput("t6_post_reset_shifts", shift_cnt, 6);
        checkOutput("t6_post_reset_done", done_cycle, 10);

        $display("Simulation finished: %0d checks, %0d errors", check_cnt, error_cnt);
        $finish;
    end
endmodule
